line_mem_responder: RTL and testbench



---
 rtl/line_mem_responder.sv | 140 ++++++++++++++
 tb/tb_line_mem_responder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/line_mem_responder.sv
// Responder for the 256-bit cache-line memory handshake: fixed-latency line read/write
// with a one-cycle ack pulse. Optional address range checking via LINE_MEM_RANGE_CHECK_EN.
module line_mem_responder #(
    parameter int LATENCY     = 10,
    parameter int DEPTH_LINES = 512,
    parameter int IDX_W       = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    input  logic         enable_i,
    input  logic         write_i,
    output logic         ack_o,
    output logic [255:0] data_o
`ifdef LINE_MEM_RANGE_CHECK_EN
    ,
    output logic         err_o
`endif
);

    // state   | meaning
    // IDLE    | waiting for enable_i; request latched on the accepting edge
    // BUSY    | latency countdown; inputs ignored
    // ACK     | ack_o high for this single cycle; store/data_o already updated
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    localparam logic [7:0] CNT_LOAD = (LATENCY > 1) ? 8'(LATENCY - 2) : 8'd0;

    logic [255:0]     mem [DEPTH_LINES];

    logic [1:0]       state;
    logic [7:0]       cnt;
    logic [IDX_W-1:0] lat_idx;
    logic [255:0]     lat_data;
    logic             lat_write;
    logic             lat_oor;

    logic             go_ack;
    logic [IDX_W-1:0] req_idx;
    logic [255:0]     req_data;
    logic             req_write;
    logic             req_oor;
    logic             addr_oor;
    logic             unused_addr;

    assign unused_addr = ^{addr_i[31:IDX_W+5], addr_i[4:0]};

`ifdef LINE_MEM_RANGE_CHECK_EN
    assign addr_oor = |addr_i[31:IDX_W+5];
`else
    assign addr_oor = 1'b0;
`endif

    // With LATENCY=1 the commit happens on the accepting edge, so the request
    // comes straight from the inputs rather than the latched copy.
    always_comb begin
        go_ack    = 1'b0;
        req_idx   = lat_idx;
        req_data  = lat_data;
        req_write = lat_write;
        req_oor   = lat_oor;
        if (state == ST_IDLE) begin
            req_idx   = addr_i[IDX_W+4:5];
            req_data  = data_i;
            req_write = write_i;
            req_oor   = addr_oor;
            go_ack    = enable_i && (LATENCY == 1);
        end else if (state == ST_BUSY) begin
            go_ack = (cnt == 8'd0);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            cnt       <= 8'd0;
            lat_idx   <= '0;
            lat_data  <= '0;
            lat_write <= 1'b0;
            lat_oor   <= 1'b0;
            ack_o     <= 1'b0;
            data_o    <= '0;
        end else begin
            ack_o <= go_ack;
            case (state)
                ST_IDLE: begin
                    if (enable_i) begin
                        lat_idx   <= addr_i[IDX_W+4:5];
                        lat_data  <= data_i;
                        lat_write <= write_i;
                        lat_oor   <= addr_oor;
                        if (LATENCY == 1) begin
                            state <= ST_ACK;
                        end else begin
                            cnt   <= CNT_LOAD;
                            state <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (cnt == 8'd0) begin
                        state <= ST_ACK;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_ACK: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
            if (go_ack && !req_write) begin
                data_o <= req_oor ? '0 : mem[req_idx];
            end
        end
    end

`ifdef LINE_MEM_RANGE_CHECK_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else begin
            err_o <= go_ack && req_oor;
        end
    end
`endif

    // Store has no reset; a write whose commit edge sees reset is dropped.
    always_ff @(posedge clk_i) begin
        if (!rst_i && go_ack && req_write && !req_oor) begin
            mem[req_idx] <= req_data;
        end
    end

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder (LATENCY=10 instance plus a LATENCY=3 instance).
module tb_line_mem_responder;

    localparam logic [255:0] D_BEEF = {8{32'hDEADBEEF}};
    localparam logic [255:0] D_Q    = {8{32'h1234_5678}};
    localparam logic [255:0] D_A    = {8{32'hAAAA_0003}};
    localparam logic [255:0] D_B    = {8{32'hBBBB_0004}};
    localparam logic [255:0] D_C    = {8{32'hCCCC_CCCC}};
    localparam logic [255:0] D_P    = {8{32'h5555_0005}};
    localparam logic [255:0] D_R    = {8{32'h0F0F_0000}};
    localparam logic [255:0] D_S    = {8{32'h7777_7777}};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  addr = '0;
    logic [255:0] data = '0;
    logic         enable = 1'b0;
    logic         write = 1'b0;
    logic         ack;
    logic [255:0] dout;
    logic         err;

    logic [31:0]  addr3 = '0;
    logic [255:0] data3 = '0;
    logic         enable3 = 1'b0;
    logic         write3 = 1'b0;
    logic         ack3;
    logic [255:0] dout3;
    logic         err3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    line_mem_responder #(.LATENCY(10)) dut (
        .clk_i(clk), .rst_i(rst), .addr_i(addr), .data_i(data),
        .enable_i(enable), .write_i(write), .ack_o(ack), .data_o(dout)
`ifdef LINE_MEM_RANGE_CHECK_EN
        , .err_o(err)
`endif
    );

    line_mem_responder #(.LATENCY(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .addr_i(addr3), .data_i(data3),
        .enable_i(enable3), .write_i(write3), .ack_o(ack3), .data_o(dout3)
`ifdef LINE_MEM_RANGE_CHECK_EN
        , .err_o(err3)
`endif
    );

`ifndef LINE_MEM_RANGE_CHECK_EN
    assign err  = 1'b0;
    assign err3 = 1'b0;
`endif

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request on the LATENCY=10 instance; lat is the cycle count
    // from acceptance to the ack cycle (0 if no ack within the bound).
    task automatic do_req(input logic w, input logic [31:0] a, input logic [255:0] d,
                          output int lat, output logic [255:0] rd, output logic ack_after,
                          output logic err_at, output logic err_after);
        @(negedge clk);
        enable = 1'b1; write = w; addr = a; data = d;
        @(negedge clk);
        enable = 1'b0; write = 1'b0; addr = 32'hFFFF_FFFF; data = ~d;
        lat = 0; rd = '0; ack_after = 1'b0; err_at = 1'b0; err_after = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (ack) begin
                lat = c; rd = dout; err_at = err;
                break;
            end
            @(negedge clk);
        end
        if (lat != 0) begin
            @(negedge clk);
            ack_after = ack; err_after = err;
        end
    endtask

    initial begin
        int lat;
        logic [255:0] rd;
        logic ack_after, err_at, err_after;
        int n_ack;
        logic [12:0] pat;

        @(negedge clk);
        check("reset_ack", {255'd0, ack}, 256'd0);
        check("reset_data", dout, 256'd0);
        check("reset_err", {255'd0, err}, 256'd0);
        @(negedge clk);
        rst = 1'b0;

        // write then read line 2
        do_req(1'b1, 32'h0000_0040, D_BEEF, lat, rd, ack_after, err_at, err_after);
        check("wr_latency", 256'(lat), 256'd10);
        check("wr_ack_one_cycle", {255'd0, ack_after}, 256'd0);
        check("wr_data_unchanged", rd, 256'd0);
        do_req(1'b0, 32'h0000_0040, '0, lat, rd, ack_after, err_at, err_after);
        check("rd_latency", 256'(lat), 256'd10);
        check("rd_data", rd, D_BEEF);
        check("rd_ack_one_cycle", {255'd0, ack_after}, 256'd0);
        check("rd_err", {255'd0, err_at}, 256'd0);
        check("rd_data_holds", dout, D_BEEF);

        // low bits ignored, upper bits wrap
        do_req(1'b1, 32'h0000_0020, D_Q, lat, rd, ack_after, err_at, err_after);
        do_req(1'b0, 32'h0000_403F, '0, lat, rd, ack_after, err_at, err_after);
        check("wrap_latency", 256'(lat), 256'd10);
`ifdef LINE_MEM_RANGE_CHECK_EN
        check("wrap_oor_data", rd, 256'd0);
        check("wrap_oor_err", {255'd0, err_at}, 256'd1);
        do_req(1'b0, 32'h0000_003F, '0, lat, rd, ack_after, err_at, err_after);
        check("lowbit_data", rd, D_Q);
`else
        check("wrap_data", rd, D_Q);
`endif

        // input changes during BUSY are ignored
        do_req(1'b1, 32'h0000_0060, D_A, lat, rd, ack_after, err_at, err_after);
        do_req(1'b1, 32'h0000_0080, D_B, lat, rd, ack_after, err_at, err_after);
        @(negedge clk);
        enable = 1'b1; write = 1'b0; addr = 32'h0000_0060;
        @(negedge clk);
        enable = 1'b0;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 3) begin
                addr = 32'h0000_0080; write = 1'b1; data = D_C; enable = 1'b1;
            end
            if (c == 5) begin
                enable = 1'b0; write = 1'b0;
            end
            if (ack) begin
                lat = c; rd = dout;
                break;
            end
            @(negedge clk);
        end
        check("busy_latency", 256'(lat), 256'd10);
        check("busy_rd_data", rd, D_A);
        n_ack = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (ack) n_ack++;
        end
        check("busy_no_second_ack", 256'(n_ack), 256'd0);
        do_req(1'b0, 32'h0000_0080, '0, lat, rd, ack_after, err_at, err_after);
        check("busy_line4_kept", rd, D_B);

        // enable held high through ack on the LATENCY=3 instance
        @(negedge clk);
        enable3 = 1'b1; write3 = 1'b0; addr3 = 32'h0000_0100;
        pat = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            pat[c] = ack3;
            if (c == 8) enable3 = 1'b0;
        end
        check("l3_ack_pattern", 256'(pat), 256'h088);

        // reset in the middle of a write
        do_req(1'b1, 32'h0000_00A0, D_P, lat, rd, ack_after, err_at, err_after);
        do_req(1'b0, 32'h0000_00A0, '0, lat, rd, ack_after, err_at, err_after);
        check("pre_reset_line5", rd, D_P);
        @(negedge clk);
        enable = 1'b1; write = 1'b1; addr = 32'h0000_00A0; data = '1;
        @(negedge clk);
        enable = 1'b0; write = 1'b0;
        n_ack = 0;
        for (int c = 1; c < 4; c++) begin
            if (ack) n_ack++;
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        check("mid_reset_ack", {255'd0, ack}, 256'd0);
        check("mid_reset_data", dout, 256'd0);
        @(negedge clk);
        check("mid_reset_ack_held", {255'd0, ack}, 256'd0);
        rst = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (ack) n_ack++;
        end
        check("reset_write_no_ack", 256'(n_ack), 256'd0);
        do_req(1'b0, 32'h0000_00A0, '0, lat, rd, ack_after, err_at, err_after);
        check("reset_line5_kept", rd, D_P);

`ifdef LINE_MEM_RANGE_CHECK_EN
        do_req(1'b1, 32'h0000_0000, D_R, lat, rd, ack_after, err_at, err_after);
        do_req(1'b1, 32'h0001_0000, D_S, lat, rd, ack_after, err_at, err_after);
        check("oor_wr_latency", 256'(lat), 256'd10);
        check("oor_wr_err", {255'd0, err_at}, 256'd1);
        check("oor_wr_err_one_cycle", {255'd0, err_after}, 256'd0);
        do_req(1'b0, 32'h0000_0000, '0, lat, rd, ack_after, err_at, err_after);
        check("oor_line0_kept", rd, D_R);
        check("inrange_err", {255'd0, err_at}, 256'd0);
        do_req(1'b0, 32'h0001_0000, '0, lat, rd, ack_after, err_at, err_after);
        check("oor_rd_data", rd, 256'd0);
        check("oor_rd_err", {255'd0, err_at}, 256'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
